// File: rtl/codec_i2c_target_model.sv
// I2C target emulating the audio CODEC control port: 7-bit device address,
// 7-bit register pointer, 9-bit registers, write commit pulse and debug read port.
`timescale 1ns/1ps
module codec_i2c_target_model #(
  parameter logic [6:0] DEVICE_ADDR    = 7'h1A,
  parameter int         NUM_REGS       = 19,
  parameter logic [6:0] RESET_REG_ADDR = 7'h0F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  input  logic [6:0] dbg_rd_addr,
  output logic [8:0] dbg_rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RXB1, RXB1_ACK, RXB2, RXB2_ACK, TXB, TX_MACK, WAIT_STOP
  } state_t;

  logic scl_s1_reg, scl_s2_reg, sda_s1_reg, sda_s2_reg;
  logic scl_prev_reg, sda_prev_reg;
  logic scl_rise_reg, scl_fall_reg, start_reg, stop_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_reg   <= 1'b1;
      scl_s2_reg   <= 1'b1;
      sda_s1_reg   <= 1'b1;
      sda_s2_reg   <= 1'b1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_s1_reg   <= i2c_scl_i;
      scl_s2_reg   <= scl_s1_reg;
      sda_s1_reg   <= i2c_sda_i;
      sda_s2_reg   <= sda_s1_reg;
      scl_prev_reg <= scl_s2_reg;
      sda_prev_reg <= sda_s2_reg;
      scl_rise_reg <= scl_s2_reg & ~scl_prev_reg;
      scl_fall_reg <= ~scl_s2_reg & scl_prev_reg;
      start_reg    <= scl_s2_reg & scl_prev_reg & sda_prev_reg & ~sda_s2_reg;
      stop_reg     <= scl_s2_reg & scl_prev_reg & ~sda_prev_reg & sda_s2_reg;
    end
  end

  // sda_prev_reg holds the SDA level that was current when the event was detected
  logic sda_bit;
  assign sda_bit = sda_prev_reg;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [6:0]  ptr_reg, ptr_next;
  logic        d8_reg, d8_next;
  logic        rw_reg, rw_next;
  logic        byte_idx_reg, byte_idx_next;
  logic        mack_reg, mack_next;
  logic        sda_t_reg, sda_t_next;
  logic        busy_reg, busy_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [6:0]  wr_addr_reg, wr_addr_next;
  logic [8:0]  wr_data_reg, wr_data_next;
  logic [8:0]  reg_vals [NUM_REGS];

  function automatic logic [8:0] reg_read(input logic [6:0] a);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == 7'(i)) v = reg_vals[i];
    return v;
  endfunction

  logic [8:0] ptr_data;
  logic [7:0] tx_byte0, tx_byte1, tx_load;

  always_comb begin
    ptr_data    = reg_read(ptr_reg);
    tx_byte0    = {ptr_reg, ptr_data[8]};
    tx_byte1    = ptr_data[7:0];
    dbg_rd_data = reg_read(dbg_rd_addr);
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    d8_next       = d8_reg;
    rw_next       = rw_reg;
    byte_idx_next = byte_idx_reg;
    mack_next     = mack_reg;
    sda_t_next    = sda_t_reg;
    busy_next     = busy_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    tx_load       = byte_idx_reg ? tx_byte0 : tx_byte1;
    if (start_reg) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      sda_t_next   = 1'b1;
      busy_next    = 1'b1;
    end else if (stop_reg) begin
      state_next   = IDLE;
      bit_cnt_next = 4'd0;
      sda_t_next   = 1'b1;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ADDR, RXB1, RXB2: begin
          if (scl_rise_reg && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_bit};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (state_reg == RXB2 && bit_cnt_reg == 4'd7) begin
              wr_valid_next = 1'b1;
              wr_addr_next  = ptr_reg;
              wr_data_next  = {d8_reg, shift_reg[6:0], sda_bit};
            end
          end else if (scl_fall_reg && bit_cnt_reg == 4'd8) begin
            sda_t_next = 1'b0;
            if (state_reg == ADDR) begin
              if (shift_reg[7:1] == DEVICE_ADDR) begin
                state_next = ADDR_ACK;
                rw_next    = shift_reg[0];
              end else begin
                state_next = WAIT_STOP;
                sda_t_next = 1'b1;
              end
            end else if (state_reg == RXB1) begin
              state_next = RXB1_ACK;
              ptr_next   = shift_reg[7:1];
              d8_next    = shift_reg[0];
            end else begin
              state_next = RXB2_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_reg) begin
            bit_cnt_next = 4'd0;
            sda_t_next   = 1'b1;
            state_next   = RXB1;
            if (rw_reg) begin
              state_next    = TXB;
              byte_idx_next = 1'b0;
              sda_t_next    = tx_byte0[7];
              shift_next    = {tx_byte0[6:0], 1'b0};
              bit_cnt_next  = 4'd1;
            end
          end
        end
        RXB1_ACK: begin
          if (scl_fall_reg) begin
            state_next   = RXB2;
            bit_cnt_next = 4'd0;
            sda_t_next   = 1'b1;
          end
        end
        RXB2_ACK: begin
          // one register per write transaction; later bytes see no ACK
          if (scl_fall_reg) begin
            state_next = WAIT_STOP;
            sda_t_next = 1'b1;
          end
        end
        TXB: begin
          if (scl_fall_reg) begin
            if (bit_cnt_reg == 4'd8) begin
              state_next = TX_MACK;
              sda_t_next = 1'b1;
            end else begin
              sda_t_next   = shift_reg[7];
              shift_next   = {shift_reg[6:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        TX_MACK: begin
          if (scl_rise_reg) begin
            mack_next = sda_bit;
          end else if (scl_fall_reg) begin
            if (!mack_reg) begin
              state_next    = TXB;
              byte_idx_next = ~byte_idx_reg;
              sda_t_next    = tx_load[7];
              shift_next    = {tx_load[6:0], 1'b0};
              bit_cnt_next  = 4'd1;
            end else begin
              state_next = WAIT_STOP;
              sda_t_next = 1'b1;
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'd0;
      ptr_reg      <= 7'd0;
      d8_reg       <= 1'b0;
      rw_reg       <= 1'b0;
      byte_idx_reg <= 1'b0;
      mack_reg     <= 1'b1;
      sda_t_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= 7'd0;
      wr_data_reg  <= 9'd0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      ptr_reg      <= ptr_next;
      d8_reg       <= d8_next;
      rw_reg       <= rw_next;
      byte_idx_reg <= byte_idx_next;
      mack_reg     <= mack_next;
      sda_t_reg    <= sda_t_next;
      busy_reg     <= busy_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  // storage lands one cycle after the commit pulse
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [6:0] IDX = 7'(gi);
    logic [8:0] val_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        val_reg <= 9'd0;
      end else if (wr_valid_reg) begin
        if (wr_addr_reg == RESET_REG_ADDR)
          val_reg <= 9'd0;
        else if (wr_addr_reg == IDX)
          val_reg <= wr_data_reg;
      end
    end
    assign reg_vals[gi] = val_reg;
  end

  assign i2c_sda_o    = 1'b0;
  assign i2c_sda_t    = sda_t_reg;
  assign busy         = busy_reg;
  assign reg_wr_valid = wr_valid_reg;
  assign reg_wr_addr  = wr_addr_reg;
  assign reg_wr_data  = wr_data_reg;

endmodule

// File: tb/tb_codec_i2c_target_model.sv
// Bench for codec_i2c_target_model: bit-banged I2C master, register map model
// and commit-pulse monitor.
`timescale 1ns/1ps
module tb_codec_i2c_target_model;

  localparam int HALF = 12;
  localparam int Q    = 6;
  localparam int NREG = 19;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       i2c_sda_o, i2c_sda_t, reg_wr_valid, busy;
  logic [6:0] reg_wr_addr;
  logic [8:0] reg_wr_data;
  logic [6:0] dbg_rd_addr = 7'd0;
  logic [8:0] dbg_rd_data;

  int checks = 0;
  int errors = 0;

  assign sda_bus = m_sda & i2c_sda_t;

  codec_i2c_target_model dut (
    .clk(clk), .reset_n(reset_n),
    .i2c_scl_i(m_scl), .i2c_sda_i(sda_bus),
    .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data), .busy(busy)
  );

  always #4 clk = ~clk;

  // commit monitor
  logic [15:0] wr_q [$];
  int   long_pulse = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reg_wr_valid) wr_q.push_back({reg_wr_addr, reg_wr_data});
    if (reg_wr_valid && prev_valid) long_pulse++;
    prev_valid = reg_wr_valid;
  end

  // register-map reference
  logic [8:0] mregs [128];
  logic [6:0] mptr;

  function automatic logic [8:0] m_read(input logic [6:0] a);
    return (int'(a) < NREG && a != 7'h0F) ? mregs[a] : 9'd0;
  endfunction

  task automatic m_write(input logic [6:0] a, input logic [8:0] d);
    if (a == 7'h0F) begin
      for (int i = 0; i < 128; i++) mregs[i] = 9'd0;
    end else if (int'(a) < NREG) begin
      mregs[a] = d;
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(Q);
    m_sda = 1'b0; clks(Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; clks(Q);
    m_scl = 1'b1; clks(Q);
    m_sda = 1'b1; clks(HALF);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; clks(Q);
    m_scl = 1'b1; clks(HALF);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(Q);
    b = sda_bus; clks(Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bt);
      b[i] = bt;
    end
    send_bit(nack);
  endtask

  task automatic full_write(input logic [6:0] a, input logic [8:0] d);
    logic nk;
    logic [15:0] got;
    i2c_start;
    write_byte(8'h34, nk);                chk("w_dev_ack", nk, 0);
    write_byte({a, d[8]}, nk);            chk("w_b1_ack", nk, 0);
    write_byte(d[7:0], nk);               chk("w_b2_ack", nk, 0);
    chk("w_busy", busy, 1);
    i2c_stop;
    chk("w_pulse_cnt", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      got = wr_q.pop_front();
      chk("w_pulse_addr_data", got, {a, d});
    end
    wr_q.delete();
    m_write(a, d);
    mptr = a;
    dbg_rd_addr = a; clks(1);
    chk("w_dbg", dbg_rd_data, m_read(a));
    $display("write reg %02h data %03h", a, d);
  endtask

  task automatic set_ptr(input logic [6:0] a);
    logic nk;
    i2c_start;
    write_byte(8'h34, nk);                chk("p_dev_ack", nk, 0);
    write_byte({a, 1'($urandom)}, nk);    chk("p_b1_ack", nk, 0);
    mptr = a;
  endtask

  task automatic full_read(input int nbytes);
    logic nk;
    logic [7:0] b;
    logic [8:0] v;
    i2c_start;
    write_byte(8'h35, nk);                chk("r_dev_ack", nk, 0);
    v = m_read(mptr);
    for (int k = 0; k < nbytes; k++) begin
      read_byte(b, (k == nbytes - 1) ? 1'b1 : 1'b0);
      chk((k % 2 == 0) ? "r_byte0" : "r_byte1", b, (k % 2 == 0) ? {mptr, v[8]} : v[7:0]);
    end
    chk("r_sda_released", i2c_sda_t, 1);
    i2c_stop;
    chk("r_busy_idle", busy, 0);
    chk("r_no_commit", wr_q.size(), 0);
    wr_q.delete();
    $display("read reg %02h bytes %0d expect %03h", mptr, nbytes, v);
  endtask

  task automatic scan_dbg(input string tag);
    for (int a = 0; a < 128; a++) begin
      dbg_rd_addr = 7'(a); clks(1);
      chk(tag, dbg_rd_data, m_read(7'(a)));
    end
    $display("debug scan %s", tag);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic nk;
    logic [6:0] a;
    logic [8:0] d;
    for (int i = 0; i < 128; i++) mregs[i] = 9'd0;
    mptr = 7'd0;

    // reset state
    clks(5);
    chk("rst_sda_t", i2c_sda_t, 1);
    chk("rst_sda_o", i2c_sda_o, 0);
    chk("rst_valid", reg_wr_valid, 0);
    chk("rst_addr", reg_wr_addr, 0);
    chk("rst_data", reg_wr_data, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    clks(10);
    $display("reset released");

    // directed write and readback with repeated START
    full_write(7'h04, 9'h1A5);
    set_ptr(7'h04);
    full_read(2);

    // wrong device address: nothing acknowledged, nothing committed
    i2c_start;
    write_byte(8'h36, nk); chk("bad_dev_nack", nk, 1);
    write_byte(8'h09, nk); chk("bad_b1_nack", nk, 1);
    write_byte(8'hA5, nk); chk("bad_b2_nack", nk, 1);
    i2c_stop;
    chk("bad_no_commit", wr_q.size(), 0);
    $display("address 0x1B ignored");

    // STOP after byte 1 sets only the pointer; read wraps byte1 -> byte0
    full_write(7'h02, 9'($urandom));
    set_ptr(7'h02);
    i2c_stop;
    chk("ptr_only_no_commit", wr_q.size(), 0);
    dbg_rd_addr = 7'h02; clks(1);
    chk("ptr_only_reg_kept", dbg_rd_data, m_read(7'h02));
    full_read(3);

    // randomized writes, including out-of-range and soft-reset addresses
    for (int n = 0; n < 8; n++) begin
      a = 7'($urandom_range(0, 22));
      d = 9'($urandom);
      full_write(a, d);
      set_ptr(a);
      full_read($urandom_range(1, 4));
    end
    scan_dbg("rand_dbg");

    // soft reset clears everything
    for (int r = 0; r < 4; r++) full_write(7'(r), 9'($urandom) | 9'h001);
    full_write(7'h0F, 9'h000);
    scan_dbg("softrst_dbg");

    // asynchronous reset in the middle of byte 2
    full_write(7'h06, 9'($urandom) | 9'h100);
    i2c_start;
    write_byte(8'h34, nk);         chk("mid_dev_ack", nk, 0);
    write_byte({7'h06, 1'b1}, nk); chk("mid_b1_ack", nk, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sda_t", i2c_sda_t, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", reg_wr_valid, 0);
    for (int i = 0; i < 128; i++) mregs[i] = 9'd0;
    mptr = 7'd0;
    m_scl = 1'b1; m_sda = 1'b1;
    clks(10);
    reset_n = 1'b1;
    clks(10);
    dbg_rd_addr = 7'h06; clks(1);
    chk("mid_rst_reg6", dbg_rd_data, 0);
    chk("mid_rst_no_commit", wr_q.size(), 0);
    $display("reset during byte 2");
    full_write(7'h06, 9'($urandom));
    set_ptr(7'h06);
    full_read(2);

    chk("pulse_width", long_pulse, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
